control_unit: RTL and testbench



---
 rtl/control_unit_if.sv | 33 +++
 rtl/control_unit.sv | 166 ++++++++++++++++
 tb/tb_control_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Decode-stage request and ID/EX control bundle between the decoder and its neighbours.
// master drives opcode/stall/flush; slave is the control_unit that returns the bundle.
interface control_unit_if;
    logic [6:0] opcode;
    logic       stall;
    logic       flush;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       ALUSrcA;
    logic       branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_lui;
    logic       is_sw;
    logic       is_lw;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       MemtoReg;
    logic       illegal_op;

    modport master (
        output opcode, stall, flush,
        input  alu_op, alu_src, ALUSrcA, branch, is_jal, is_jalr, is_lui, is_sw, is_lw,
               MemRead, MemWrite, RegWrite, MemtoReg, illegal_op
    );

    modport slave (
        input  opcode, stall, flush,
        output alu_op, alu_src, ALUSrcA, branch, is_jal, is_jalr, is_lui, is_sw, is_lw,
               MemRead, MemWrite, RegWrite, MemtoReg, illegal_op
    );
endinterface

// File: rtl/control_unit.sv
// RV32 main decoder: opcode -> control bundle, registered at the ID/EX boundary with stall/flush.
// Define CONTROL_UNIT_ILLEGAL_OP_EN to register an illegal-opcode flag; otherwise illegal_op is 0.
module control_unit (
    input logic           clk,
    input logic           rst_n,
    control_unit_if.slave bus
);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       alu_src_a;
        logic       branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_lui;
        logic       is_sw;
        logic       is_lw;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    ctrl_t dec;
    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    // Unlisted opcodes fall through to an all-zero bundle: a no-op that never writes state.
    always_comb begin
        dec = '0;
        case (bus.opcode)
            OpR: begin
                dec.alu_op    = 2'b10;
                dec.reg_write = 1'b1;
            end
            OpIAlu: begin
                dec.alu_op    = 2'b10;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OpLoad: begin
                dec.alu_op     = 2'b00;
                dec.alu_src    = 1'b1;
                dec.is_lw      = 1'b1;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
            end
            OpJalr: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 1'b1;
                dec.is_jalr   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OpStore: begin
                dec.alu_op    = 2'b00;
                dec.alu_src   = 1'b1;
                dec.is_sw     = 1'b1;
                dec.mem_write = 1'b1;
            end
            OpBr: begin
                dec.alu_op = 2'b01;
                dec.branch = 1'b1;
            end
            OpJal: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 1'b1;
                dec.is_jal    = 1'b1;
                dec.reg_write = 1'b1;
            end
            OpLui: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 1'b1;
                dec.is_lui    = 1'b1;
                dec.reg_write = 1'b1;
            end
            OpAuipc: begin
                dec.alu_op    = 2'b11;
                dec.alu_src   = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: dec = '0;
        endcase
    end

    // Flush beats stall so a squashed slot never survives a concurrent hold.
    always_comb begin
        if (bus.flush) begin
            ctrl_d = '0;
        end else if (bus.stall) begin
            ctrl_d = ctrl_q;
        end else begin
            ctrl_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign bus.alu_op   = ctrl_q.alu_op;
    assign bus.alu_src  = ctrl_q.alu_src;
    assign bus.ALUSrcA  = ctrl_q.alu_src_a;
    assign bus.branch   = ctrl_q.branch;
    assign bus.is_jal   = ctrl_q.is_jal;
    assign bus.is_jalr  = ctrl_q.is_jalr;
    assign bus.is_lui   = ctrl_q.is_lui;
    assign bus.is_sw    = ctrl_q.is_sw;
    assign bus.is_lw    = ctrl_q.is_lw;
    assign bus.MemRead  = ctrl_q.mem_read;
    assign bus.MemWrite = ctrl_q.mem_write;
    assign bus.RegWrite = ctrl_q.reg_write;
    assign bus.MemtoReg = ctrl_q.mem_to_reg;

`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
    logic illegal_dec;
    logic illegal_d;
    logic illegal_q;

    always_comb begin
        case (bus.opcode)
            OpR, OpIAlu, OpLoad, OpJalr, OpStore, OpBr, OpJal, OpLui, OpAuipc: illegal_dec = 1'b0;
            default: illegal_dec = 1'b1;
        endcase
    end

    always_comb begin
        if (bus.flush) begin
            illegal_d = 1'b0;
        end else if (bus.stall) begin
            illegal_d = illegal_q;
        end else begin
            illegal_d = illegal_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign bus.illegal_op = illegal_q;
`else
    assign bus.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed plan steps, then randomized opcode/stall/flush
// traffic against a rule-based reference model.
module tb_control_unit;

    logic clk;
    logic rst_n;

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle, MSB first: alu_op, alu_src, ALUSrcA, branch, jal, jalr, lui, sw, lw,
    // MemRead, MemWrite, RegWrite, MemtoReg, illegal_op.
    logic [14:0] obs;
    assign obs = {bus.alu_op, bus.alu_src, bus.ALUSrcA, bus.branch, bus.is_jal, bus.is_jalr,
                  bus.is_lui, bus.is_sw, bus.is_lw, bus.MemRead, bus.MemWrite, bus.RegWrite,
                  bus.MemtoReg, bus.illegal_op};

    int checks = 0;
    int errors = 0;
    logic [14:0] model_q;

    localparam logic [6:0] LegalOps [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                            7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111,
                                            7'b0010111};

    // Derived from instruction-class rules rather than a per-opcode table.
    function automatic logic [14:0] ref_decode(input logic [6:0] op);
        logic is_r, is_i, lw, sw, br, jal, jalr, lui, auipc, legal, ill;
        logic [1:0] aop;
        is_r  = (op == 7'b0110011);
        is_i  = (op == 7'b0010011);
        lw    = (op == 7'b0000011);
        sw    = (op == 7'b0100011);
        br    = (op == 7'b1100011);
        jal   = (op == 7'b1101111);
        jalr  = (op == 7'b1100111);
        lui   = (op == 7'b0110111);
        auipc = (op == 7'b0010111);
        legal = is_r | is_i | lw | sw | br | jal | jalr | lui | auipc;
`ifdef CONTROL_UNIT_ILLEGAL_OP_EN
        ill = !legal;
`else
        ill = 1'b0;
`endif
        if (!legal || lw || sw) aop = 2'b00;
        else if (br)            aop = 2'b01;
        else if (is_r || is_i)  aop = 2'b10;
        else                    aop = 2'b11;
        return {aop, legal && !br && !is_r, auipc, br, jal, jalr, lui, sw, lw, lw, sw,
                legal && !sw && !br, lw, ill};
    endfunction

    task automatic check(input string tag);
        checks++;
        assert (obs === model_q) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, model_q);
        end
    endtask

    // One clock edge: the model applies flush > stall > decode, then outputs are sampled at +1.
    task automatic step(input string tag);
        logic [14:0] nxt;
        if (bus.flush)      nxt = '0;
        else if (bus.stall) nxt = model_q;
        else                nxt = ref_decode(bus.opcode);
        @(posedge clk);
        model_q = nxt;
        #1;
        check(tag);
    endtask

    task automatic drive(input logic [6:0] op, input logic st, input logic fl);
        bus.opcode = op;
        bus.stall  = st;
        bus.flush  = fl;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(7'b0110011, 1'b0, 1'b0);
        #1;
        rst_n   = 1'b0;
        model_q = '0;
        #1;
        check("reset_async");
        @(posedge clk);
        #1;
        check("reset_held_edge");
        #2;
        rst_n = 1'b1;
        check("reset_release_before_edge");
        step("first_decode_r");

        for (int i = 1; i < 9; i++) begin
            drive(LegalOps[i], 1'b0, 1'b0);
            step($sformatf("sweep_%b", LegalOps[i]));
        end

        drive(7'b1111111, 1'b0, 1'b0);
        step("illegal_1111111");
        drive(7'b0000000, 1'b0, 1'b0);
        step("illegal_0000000");
        drive(7'b0110001, 1'b0, 1'b0);
        step("illegal_low_bits");

        drive(7'b0000011, 1'b0, 1'b0);
        step("stall_load");
        drive(7'b0100011, 1'b1, 1'b0);
        step("stall_hold1");
        step("stall_hold2");
        drive(7'b0100011, 1'b0, 1'b0);
        step("stall_release_store");

        drive(7'b1101111, 1'b0, 1'b0);
        step("flush_setup_jal");
        drive(7'b1101111, 1'b1, 1'b1);
        step("flush_beats_stall");

        drive(7'b0010111, 1'b0, 1'b0);
        step("midreset_auipc");
        #2;
        rst_n   = 1'b0;
        model_q = '0;
        #1;
        check("midreset_async");
        #1;
        rst_n = 1'b1;
        #1;
        check("midreset_released_no_replay");
        step("midreset_first_edge");

        for (int i = 0; i < 300; i++) begin
            logic [6:0] op;
            if ($urandom_range(1, 0) == 1) op = LegalOps[$urandom_range(8, 0)];
            else                           op = 7'($urandom);
            drive(op, ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0));
            step($sformatf("rand_%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
